// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter: shares the single vga_adapter pixel-write port among
// NUM_REQ drawing engines. A frame_start pulse (or reset release) triggers a
// full-screen clear sweep to BG_COLOUR; otherwise valid/ready pixel requests
// are served round-robin at one pixel per cycle.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ST_ARB    | round-robin grant of pixel requests, one per cycle
//   ST_CLEAR  | raster sweep writing BG_COLOUR to every pixel, no grants
module vga_plot_arbiter #(
   parameter int          NUM_REQ        = 3,
   parameter int          H_RES          = 320,
   parameter int          V_RES          = 240,
   parameter logic [2:0]  BG_COLOUR      = 3'b000,
   parameter bit          CLEAR_ON_RESET = 1'b1
) (
   input  logic                   CLOCK_50,
   input  logic                   resetn,
   input  logic                   frame_start,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [9*NUM_REQ-1:0]   req_x,
   input  logic [8*NUM_REQ-1:0]   req_y,
   input  logic [3*NUM_REQ-1:0]   req_colour,
   output logic [NUM_REQ-1:0]     req_ready,
   output logic [8:0]             x,
   output logic [7:0]             y,
   output logic [2:0]             colour,
   output logic                   writeEn,
   output logic                   clear_busy,
   output logic                   clear_done,
   output logic                   drop
);

   localparam int          PTR_W   = $clog2(NUM_REQ);
   localparam logic [8:0]  CX_LAST = 9'(H_RES - 1);
   localparam logic [7:0]  CY_LAST = 8'(V_RES - 1);
   localparam logic [9:0]  H_LIM   = 10'(H_RES);
   localparam logic [8:0]  V_LIM   = 9'(V_RES);

   typedef enum logic {ST_ARB, ST_CLEAR} state_e;

   state_e            state_q;
   logic [PTR_W-1:0]  rr_ptr_q;
   logic [8:0]        cx_q;
   logic [7:0]        cy_q;
   logic [8:0]        x_q;
   logic [7:0]        y_q;
   logic [2:0]        colour_q;
   logic              we_q;
   logic              done_pend_q;
   logic              clear_done_q;
   logic              drop_q;

   logic              gnt_valid;
   logic [PTR_W-1:0]  gnt_idx;
   logic [PTR_W-1:0]  probe_idx;
   logic [PTR_W-1:0]  rr_ptr_d;
   logic [8:0]        gnt_x;
   logic [7:0]        gnt_y;
   logic [2:0]        gnt_colour;
   logic              gnt_in_range;

   // Round-robin search starting at rr_ptr; frame_start blocks any grant.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      probe_idx = '0;
      req_ready = '0;
      if (state_q == ST_ARB && !frame_start) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            probe_idx = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!gnt_valid && req_valid[probe_idx]) begin
               gnt_valid = 1'b1;
               gnt_idx   = probe_idx;
            end
         end
      end
      if (gnt_valid) begin
         req_ready[gnt_idx] = 1'b1;
      end
   end

   // Fields of the granted requester and the pointer that follows it.
   always_comb begin
      gnt_x        = req_x[9*int'(gnt_idx) +: 9];
      gnt_y        = req_y[8*int'(gnt_idx) +: 8];
      gnt_colour   = req_colour[3*int'(gnt_idx) +: 3];
      gnt_in_range = ({1'b0, gnt_x} < H_LIM) && ({1'b0, gnt_y} < V_LIM);
      rr_ptr_d     = PTR_W'((int'(gnt_idx) + 1) % NUM_REQ);
   end

   // Frame sequencer: state, sweep counters, pointer and registered pixel port.
   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         state_q      <= CLEAR_ON_RESET ? ST_CLEAR : ST_ARB;
         rr_ptr_q     <= '0;
         cx_q         <= '0;
         cy_q         <= '0;
         x_q          <= '0;
         y_q          <= '0;
         colour_q     <= '0;
         we_q         <= 1'b0;
         done_pend_q  <= 1'b0;
         clear_done_q <= 1'b0;
         drop_q       <= 1'b0;
      end else begin
         we_q         <= 1'b0;
         drop_q       <= 1'b0;
         done_pend_q  <= 1'b0;
         // clear_done trails the final sweep write by one cycle
         clear_done_q <= done_pend_q;
         if (frame_start) begin
            state_q <= ST_CLEAR;
            cx_q    <= '0;
            cy_q    <= '0;
         end else if (state_q == ST_CLEAR) begin
            x_q      <= cx_q;
            y_q      <= cy_q;
            colour_q <= BG_COLOUR;
            we_q     <= 1'b1;
            if (cx_q == CX_LAST) begin
               cx_q <= '0;
               if (cy_q == CY_LAST) begin
                  cy_q        <= '0;
                  state_q     <= ST_ARB;
                  done_pend_q <= 1'b1;
               end else begin
                  cy_q <= cy_q + 8'd1;
               end
            end else begin
               cx_q <= cx_q + 9'd1;
            end
         end else if (gnt_valid) begin
            x_q      <= gnt_x;
            y_q      <= gnt_y;
            colour_q <= gnt_colour;
            we_q     <= gnt_in_range;
            drop_q   <= !gnt_in_range;
            rr_ptr_q <= rr_ptr_d;
         end
      end
   end

   assign x          = x_q;
   assign y          = y_q;
   assign colour     = colour_q;
   assign writeEn    = we_q;
   assign clear_done = clear_done_q;
   assign drop       = drop_q;
   assign clear_busy = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Bench for vga_plot_arbiter with a reduced screen so every clear sweep is
// checked pixel by pixel; arbitration is checked against a round-robin model.
module tb_vga_plot_arbiter;

   localparam int          NR   = 3;
   localparam int          HR   = 160;
   localparam int          VR   = 60;
   localparam logic [2:0]  BG   = 3'b010;
   localparam int          NPIX = HR * VR;

   logic              clk;
   logic              resetn;
   logic              frame_start;
   logic [NR-1:0]     req_valid;
   logic [9*NR-1:0]   req_x;
   logic [8*NR-1:0]   req_y;
   logic [3*NR-1:0]   req_colour;
   logic [NR-1:0]     req_ready;
   logic [8:0]        x;
   logic [7:0]        y;
   logic [2:0]        colour;
   logic              writeEn;
   logic              clear_busy;
   logic              clear_done;
   logic              drop;

   int checks = 0;
   int errors = 0;

   // reference model: pointer, pending requester fields, last expected outputs
   int          mptr;
   logic [8:0]  fx [NR];
   logic [7:0]  fy [NR];
   logic [2:0]  fc [NR];
   logic [8:0]  ex;
   logic [7:0]  ey;
   logic [2:0]  ec;

   vga_plot_arbiter #(
      .NUM_REQ(NR), .H_RES(HR), .V_RES(VR), .BG_COLOUR(BG), .CLEAR_ON_RESET(1'b1)
   ) dut (
      .CLOCK_50(clk), .resetn(resetn), .frame_start(frame_start),
      .req_valid(req_valid), .req_x(req_x), .req_y(req_y), .req_colour(req_colour),
      .req_ready(req_ready), .x(x), .y(y), .colour(colour), .writeEn(writeEn),
      .clear_busy(clear_busy), .clear_done(clear_done), .drop(drop)
   );

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive_fields();
      for (int i = 0; i < NR; i++) begin
         req_x[9*i +: 9]      = fx[i];
         req_y[8*i +: 8]      = fy[i];
         req_colour[3*i +: 3] = fc[i];
      end
   endtask

   task automatic new_fields(input int i);
      fx[i] = ($urandom_range(0, 5) == 0) ? 9'($urandom_range(HR, 511)) : 9'($urandom_range(0, HR-1));
      fy[i] = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(VR, 255)) : 8'($urandom_range(0, VR-1));
      fc[i] = 3'($urandom_range(0, 7));
   endtask

   // one arbitration cycle: predict grant, check ready, then check the plotted pixel
   task automatic arb_cycle(input logic [NR-1:0] v, output int g);
      logic [NR-1:0] exp_rdy;
      bit ok;
      req_valid = v;
      drive_fields();
      #1;
      g = -1;
      for (int k = 0; k < NR; k++) begin
         int i = (mptr + k) % NR;
         if (g < 0 && v[i]) g = i;
      end
      exp_rdy = (g < 0) ? '0 : NR'(1 << g);
      chk("arb_ready", 32'(req_ready), 32'(exp_rdy));
      ok = 1'b0;
      if (g >= 0) begin
         ok   = (int'(fx[g]) < HR) && (int'(fy[g]) < VR);
         ex   = fx[g];
         ey   = fy[g];
         ec   = fc[g];
         mptr = (g + 1) % NR;
      end
      step();
      chk("arb_x", 32'(x), 32'(ex));
      chk("arb_y", 32'(y), 32'(ey));
      chk("arb_colour", 32'(colour), 32'(ec));
      chk("arb_we", 32'(writeEn), 32'((g >= 0) && ok));
      chk("arb_drop", 32'(drop), 32'((g >= 0) && !ok));
      chk("arb_busy", 32'(clear_busy), 32'd0);
      if (g >= 0) new_fields(g);
   endtask

   // step until the first sweep write is visible (bounded), checking no grants meanwhile
   task automatic wait_first_write();
      for (int t = 0; t < 3; t++) begin
         if (writeEn === 1'b1) break;
         req_valid = NR'($urandom_range(0, 7));
         #1;
         chk("gap_ready", 32'(req_ready), 32'd0);
         step();
      end
   endtask

   // entered with sweep write 0 visible; stop_at >= 0 aborts with frame_start at that write
   task automatic run_sweep(input int stop_at);
      for (int n = 0; n < NPIX; n++) begin
         bit last = (n == NPIX - 1);
         chk("clr_we", 32'(writeEn), 32'd1);
         chk("clr_x", 32'(x), 32'(n % HR));
         chk("clr_y", 32'(y), 32'(n / HR));
         chk("clr_colour", 32'(colour), 32'(BG));
         chk("clr_done_low", 32'(clear_done), 32'd0);
         chk("clr_busy", 32'(clear_busy), 32'(!last));
         if (n == stop_at) begin
            frame_start = 1'b1;
            req_valid   = '1;
            #1;
            chk("fs_clr_ready", 32'(req_ready), 32'd0);
            step();
            frame_start = 1'b0;
            return;
         end
         req_valid = last ? '0 : NR'($urandom_range(0, 7));
         #1;
         if (!last) chk("clr_ready", 32'(req_ready), 32'd0);
         step();
      end
      chk("done_pulse", 32'(clear_done), 32'd1);
      chk("done_we", 32'(writeEn), 32'd0);
      chk("done_drop", 32'(drop), 32'd0);
      chk("done_busy", 32'(clear_busy), 32'd0);
      ex = 9'(HR - 1);
      ey = 8'(VR - 1);
      ec = BG;
      step();
      chk("done_one_cycle", 32'(clear_done), 32'd0);
      chk("post_we", 32'(writeEn), 32'd0);
      chk("post_x", 32'(x), 32'(HR - 1));
   endtask

   initial begin
      int g;
      logic [NR-1:0] v;
      logic [NR-1:0] gm;

      resetn      = 1'b0;
      frame_start = 1'b0;
      req_valid   = '0;
      for (int i = 0; i < NR; i++) new_fields(i);
      drive_fields();
      mptr = 0;
      ex = '0;
      ey = '0;
      ec = '0;

      // reset state
      step();
      step();
      chk("rst_x", 32'(x), 32'd0);
      chk("rst_y", 32'(y), 32'd0);
      chk("rst_colour", 32'(colour), 32'd0);
      chk("rst_we", 32'(writeEn), 32'd0);
      chk("rst_done", 32'(clear_done), 32'd0);
      chk("rst_drop", 32'(drop), 32'd0);
      chk("rst_busy", 32'(clear_busy), 32'd1);
      chk("rst_ready", 32'(req_ready), 32'd0);

      // clear sweep after reset release
      resetn = 1'b1;
      wait_first_write();
      run_sweep(-1);

      // all requesters valid: strict rotation 0,1,2,0,1,2
      for (int k = 0; k < 6; k++) begin
         req_valid = '1;
         drive_fields();
         #1;
         chk("t2_order", 32'(req_ready), 32'(1 << (k % NR)));
         arb_cycle('1, g);
      end

      // single requester 2
      fx[2] = 9'd100;
      fy[2] = 8'd50;
      fc[2] = 3'b101;
      arb_cycle(3'b100, g);
      chk("t3_x", 32'(x), 32'd100);
      chk("t3_y", 32'(y), 32'd50);
      chk("t3_colour", 32'(colour), 32'd5);
      chk("t3_we", 32'(writeEn), 32'd1);

      // out-of-range x accepted and dropped; pointer moves past requester 1
      fx[1] = 9'(HR);
      fy[1] = 8'd10;
      arb_cycle(3'b010, g);
      chk("t4_we", 32'(writeEn), 32'd0);
      chk("t4_drop", 32'(drop), 32'd1);
      req_valid = '1;
      drive_fields();
      #1;
      chk("t4_ptr", 32'(req_ready), 32'b100);
      arb_cycle('1, g);

      // corner pixel accepted, first row past the bottom dropped
      fx[0] = 9'(HR - 1);
      fy[0] = 8'(VR - 1);
      arb_cycle(3'b001, g);
      chk("edge_in_we", 32'(writeEn), 32'd1);
      fx[0] = 9'd5;
      fy[0] = 8'(VR);
      arb_cycle(3'b001, g);
      chk("edge_out_drop", 32'(drop), 32'd1);

      // idle cycles hold the pointer
      arb_cycle('0, g);
      arb_cycle('0, g);

      // random traffic; an ungranted valid stays up with stable fields
      v  = '0;
      gm = '0;
      for (int c = 0; c < 300; c++) begin
         v = (v & ~gm) | NR'($urandom_range(0, 7));
         arb_cycle(v, g);
         gm = (g < 0) ? '0 : NR'(1 << g);
      end

      // frame_start in ARB overrides a pending handshake
      req_valid   = '1;
      frame_start = 1'b1;
      drive_fields();
      #1;
      chk("fs_arb_ready", 32'(req_ready), 32'd0);
      step();
      frame_start = 1'b0;
      chk("fs_arb_we", 32'(writeEn), 32'd0);
      chk("fs_arb_drop", 32'(drop), 32'd0);
      chk("fs_arb_busy", 32'(clear_busy), 32'd1);
      wait_first_write();
      run_sweep(40 * HR + 150);
      wait_first_write();
      run_sweep(-1);

      // pointer survives the clear
      for (int c = 0; c < 20; c++) begin
         v = (v & ~gm) | NR'($urandom_range(0, 7));
         arb_cycle(v, g);
         gm = (g < 0) ? '0 : NR'(1 << g);
      end

      // reset mid-ARB with requests pending
      req_valid = '1;
      resetn    = 1'b0;
      step();
      chk("t6_we", 32'(writeEn), 32'd0);
      chk("t6_x", 32'(x), 32'd0);
      chk("t6_y", 32'(y), 32'd0);
      chk("t6_colour", 32'(colour), 32'd0);
      chk("t6_drop", 32'(drop), 32'd0);
      chk("t6_busy", 32'(clear_busy), 32'd1);
      resetn = 1'b1;
      mptr = 0;
      wait_first_write();
      run_sweep(-1);
      arb_cycle('1, g);
      arb_cycle('1, g);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
